// File: rtl/mac_pipe.sv
// Pipelined signed multiply-accumulate: A*A +/- COEF*B, A*B or accumulate,
// with saturate/wrap reduction and a single global valid/ready advance.
module mac_pipe #(
  parameter int W     = 8,
  parameter int CW    = 8,
  parameter int COEF  = 97,
  parameter int DEPTH = 4,
  parameter bit SAT   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic signed [W-1:0]   A,
  input  logic signed [W-1:0]   B,
  input  logic [1:0]            MODE,
  input  logic                  CLR_ACC,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic signed [2*W-1:0] RESULT,
  output logic                  OVF
);

  localparam int OW = 2 * W;
  localparam int SW = 2 * W + CW + 2;
  localparam int NP = DEPTH - 1;
  localparam logic signed [CW-1:0] COEF_C = CW'(COEF);

  // Range test and reduction of a full-precision sum to OW bits.
  function automatic logic [OW:0] reduce_fn(input logic signed [SW-1:0] s);
    logic          out_rng;
    logic [OW-1:0] r;
    out_rng = (s[SW-1:OW-1] != '0) && (s[SW-1:OW-1] != '1);
    if (SAT && out_rng)
      r = s[SW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    else
      r = s[OW-1:0];
    return {out_rng, r};
  endfunction

  logic                 advance;
  logic signed [SW-1:0] a_ext, b_ext, c_ext;
  logic signed [SW-1:0] aa, ab, cb;

  logic                 vld_d  [1:NP];
  logic                 vld_q  [1:NP];
  logic signed [SW-1:0] pa_d   [1:NP];
  logic signed [SW-1:0] pa_q   [1:NP];
  logic signed [SW-1:0] pb_d   [1:NP];
  logic signed [SW-1:0] pb_q   [1:NP];
  logic [1:0]           mode_d [1:NP];
  logic [1:0]           mode_q [1:NP];
  logic                 clr_d  [1:NP];
  logic                 clr_q  [1:NP];

  logic signed [SW-1:0] base_p, sum_p;
  logic [OW:0]          red_p;
  logic                 out_valid_d, out_valid_q;
  logic                 ovf_d, ovf_q;
  logic signed [OW-1:0] result_d, result_q;
  logic signed [OW-1:0] acc_d, acc_q;

  always_comb begin
    advance = !out_valid_q || OUT_READY;
    a_ext   = SW'(A);
    b_ext   = SW'(B);
    c_ext   = SW'(COEF_C);
    aa      = a_ext * a_ext;
    ab      = a_ext * b_ext;
    cb      = c_ext * b_ext;

    for (int k = 1; k <= NP; k++) begin
      vld_d[k]  = vld_q[k];
      pa_d[k]   = pa_q[k];
      pb_d[k]   = pb_q[k];
      mode_d[k] = mode_q[k];
      clr_d[k]  = clr_q[k];
    end

    if (advance) begin
      // Stage 1: mode picks the products so the output stage only adds.
      vld_d[1]  = IN_VALID;
      pa_d[1]   = (MODE == 2'd1) ? ab : aa;
      case (MODE)
        2'd1:    pb_d[1] = '0;
        2'd3:    pb_d[1] = -cb;
        default: pb_d[1] = cb;
      endcase
      mode_d[1] = MODE;
      clr_d[1]  = CLR_ACC;
      // Stages 2..DEPTH-1: pure delay
      for (int k = 2; k <= NP; k++) begin
        vld_d[k]  = vld_q[k-1];
        pa_d[k]   = pa_q[k-1];
        pb_d[k]   = pb_q[k-1];
        mode_d[k] = mode_q[k-1];
        clr_d[k]  = clr_q[k-1];
      end
    end
  end

  // Stage DEPTH: add, reduce, and fold mode-2 results back into ACC
  always_comb begin
    base_p = (mode_q[NP] == 2'd2 && !clr_q[NP]) ? SW'(acc_q) : '0;
    sum_p  = base_p + pa_q[NP] + pb_q[NP];
    red_p  = reduce_fn(sum_p);

    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    if (advance) begin
      out_valid_d = vld_q[NP];
      if (vld_q[NP]) begin
        result_d = red_p[OW-1:0];
        ovf_d    = red_p[OW];
        if (mode_q[NP] == 2'd2)
          acc_d = red_p[OW-1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 1; k <= NP; k++) vld_q[k] <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      for (int k = 1; k <= NP; k++) vld_q[k] <= vld_d[k];
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 1; k <= NP; k++) begin
      pa_q[k]   <= pa_d[k];
      pb_q[k]   <= pb_d[k];
      mode_q[k] <= mode_d[k];
      clr_q[k]  <= clr_d[k];
    end
  end

  assign IN_READY  = advance;
  assign OUT_VALID = out_valid_q;
  assign RESULT    = result_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: a saturating and a wrapping instance share stimulus and
// are checked against a slot-level model of latency and arithmetic.
module tb_mac_pipe;

  localparam int D      = 4;
  localparam int COEF_T = 97;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [7:0] a_in = '0;
  logic signed [7:0] b_in = '0;
  logic [1:0] mode_in = '0;
  logic clr_in = 1'b0;

  logic in_ready_s, out_valid_s, ovf_s;
  logic signed [15:0] result_s;
  logic in_ready_w, out_valid_w, ovf_w;
  logic signed [15:0] result_w;

  always #5 clk = ~clk;

  mac_pipe #(.W(8), .CW(8), .COEF(COEF_T), .DEPTH(D), .SAT(1'b1)) dut_s (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready_s),
    .A(a_in), .B(b_in), .MODE(mode_in), .CLR_ACC(clr_in),
    .OUT_VALID(out_valid_s), .OUT_READY(out_ready), .RESULT(result_s), .OVF(ovf_s));

  mac_pipe #(.W(8), .CW(8), .COEF(COEF_T), .DEPTH(D), .SAT(1'b0)) dut_w (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready_w),
    .A(a_in), .B(b_in), .MODE(mode_in), .CLR_ACC(clr_in),
    .OUT_VALID(out_valid_w), .OUT_READY(out_ready), .RESULT(result_w), .OVF(ovf_w));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: D slots of expected transactions, oldest at slot D.
  bit                 mv  [1:D];
  logic signed [15:0] mrs [1:D];
  logic signed [15:0] mrw [1:D];
  bit                 mos [1:D];
  bit                 mow [1:D];
  longint             acc_s = 0;
  longint             acc_w = 0;
  bit                 last_acc;

  logic signed [15:0] rets[$];
  logic signed [15:0] retw[$];
  bit                 retos[$];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_txn(input int m, input bit c, input int av, input int bv,
                           output logic signed [15:0] rs, output bit os,
                           output logic signed [15:0] rw, output bit ow);
    longint p, ss, sw;
    case (m)
      1:       p = longint'(av) * av - longint'(av) * av + longint'(av) * bv;
      3:       p = longint'(av) * av - COEF_T * longint'(bv);
      default: p = longint'(av) * av + COEF_T * longint'(bv);
    endcase
    ss = p;
    sw = p;
    if (m == 2 && !c) begin
      ss += acc_s;
      sw += acc_w;
    end
    os = (ss > 32767) || (ss < -32768);
    if (ss > 32767) ss = 32767;
    else if (ss < -32768) ss = -32768;
    rs = ss[15:0];
    ow = (sw > 32767) || (sw < -32768);
    rw = sw[15:0];
    if (m == 2) begin
      acc_s = rs;
      acc_w = rw;
    end
  endtask

  task automatic model_clear();
    for (int k = 1; k <= D; k++) mv[k] = 1'b0;
    acc_s = 0;
    acc_w = 0;
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic cycle();
    bit exp_rdy, acc_now;
    #1;
    exp_rdy = !mv[D] || out_ready;
    check("in_ready_sat", in_ready_s, exp_rdy);
    check("in_ready_wrap", in_ready_w, exp_rdy);
    if (out_valid_s && out_ready) begin
      rets.push_back(result_s);
      retos.push_back(ovf_s);
    end
    if (out_valid_w && out_ready) retw.push_back(result_w);
    acc_now  = in_valid && exp_rdy;
    last_acc = acc_now;
    @(posedge clk);
    if (exp_rdy) begin
      for (int k = D; k >= 2; k--) begin
        mv[k] = mv[k-1]; mrs[k] = mrs[k-1]; mrw[k] = mrw[k-1];
        mos[k] = mos[k-1]; mow[k] = mow[k-1];
      end
      mv[1] = acc_now;
      if (acc_now)
        model_txn(int'(mode_in), clr_in, int'(a_in), int'(b_in),
                  mrs[1], mos[1], mrw[1], mow[1]);
    end
    #1;
    check("out_valid_sat", out_valid_s, mv[D]);
    check("out_valid_wrap", out_valid_w, mv[D]);
    if (mv[D]) begin
      check("result_sat", result_s, mrs[D]);
      check("ovf_sat", ovf_s, mos[D]);
      check("result_wrap", result_w, mrw[D]);
      check("ovf_wrap", ovf_w, mow[D]);
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] m, input bit c,
                       input int av, input int bv);
    in_valid = v; mode_in = m; clr_in = c;
    a_in = 8'(av); b_in = 8'(bv); out_ready = 1'b1;
    cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < D + 1; i++) drive(1'b0, 2'd0, 1'b0, 0, 0);
  endtask

  task automatic clear_rets();
    rets.delete(); retw.delete(); retos.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid_s | out_valid_w, 1'b0);
    check({tag, "_result_sat"}, result_s, 0);
    check({tag, "_result_wrap"}, result_w, 0);
    check({tag, "_ovf"}, ovf_s | ovf_w, 1'b0);
    check({tag, "_in_ready"}, in_ready_s & in_ready_w, 1'b1);
  endtask

  int e_m0[3]   = '{106, 3968, 28703};
  int e_m13[2]  = '{-16256, -12319};
  int e_accs[3] = '{19700, 32767, 1};
  int e_accw[3] = '{19700, -26136, 1};
  int e_acco[3] = '{0, 1, 0};

  initial begin
    int idx, stall_left;
    bit stall_started;

    // Power-on reset
    model_clear();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Mode 0
    clear_rets();
    drive(1'b1, 2'd0, 1'b0, 3, 1);
    drive(1'b1, 2'd0, 1'b0, -128, -128);
    drive(1'b1, 2'd0, 1'b0, -128, 127);
    drain();
    check("m0_count", rets.size(), 3);
    if (rets.size() == 3)
      for (int i = 0; i < 3; i++) begin
        check("m0_value", rets[i], e_m0[i]);
        check("m0_ovf", retos[i], 1'b0);
      end

    // Modes 1 and 3
    clear_rets();
    drive(1'b1, 2'd1, 1'b0, 127, -128);
    drive(1'b1, 2'd3, 1'b1, 0, 127);
    drain();
    check("m13_count", rets.size(), 2);
    if (rets.size() == 2)
      for (int i = 0; i < 2; i++) check("m13_value", rets[i], e_m13[i]);

    // Accumulation, overflow and clear
    clear_rets();
    drive(1'b1, 2'd2, 1'b1, 100, 100);
    drive(1'b1, 2'd2, 1'b0, 100, 100);
    drive(1'b1, 2'd2, 1'b1, 1, 0);
    drain();
    check("acc_count_sat", rets.size(), 3);
    check("acc_count_wrap", retw.size(), 3);
    if (rets.size() == 3 && retw.size() == 3)
      for (int i = 0; i < 3; i++) begin
        check("acc_sat_value", rets[i], e_accs[i]);
        check("acc_sat_ovf", retos[i], e_acco[i]);
        check("acc_wrap_value", retw[i], e_accw[i]);
      end

    // Backpressure: OUT_READY low for 3 cycles once OUT_VALID rises
    clear_rets();
    idx = 1; stall_left = 0; stall_started = 1'b0;
    for (int cyc = 0; cyc < 40 && !(idx > 6 && rets.size() == 6); cyc++) begin
      in_valid = (idx <= 6); mode_in = 2'd0; clr_in = 1'b0;
      a_in = 8'(idx); b_in = 8'(0);
      out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
      cycle();
      if (last_acc) idx++;
      if (stall_left > 0) stall_left--;
      if (!stall_started && mv[D]) begin
        stall_started = 1'b1;
        stall_left = 3;
      end
    end
    drain();
    check("bp_count", rets.size(), 6);
    if (rets.size() == 6)
      for (int i = 0; i < 6; i++) check("bp_value", rets[i], (i + 1) * (i + 1));

    // Asynchronous reset with three transactions in flight
    drive(1'b1, 2'd2, 1'b0, 2, 0);
    drive(1'b1, 2'd2, 1'b0, 3, 0);
    drive(1'b1, 2'd0, 1'b0, 4, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_clear();
    #1 check_reset_outputs("rst_mid");
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    clear_rets();
    drain();
    check("rst_nothing_emerges", rets.size() + retw.size(), 0);
    clear_rets();
    drive(1'b1, 2'd2, 1'b0, 1, 0);
    drain();
    check("rst_acc_cleared_count", rets.size(), 1);
    if (rets.size() == 1) check("rst_acc_cleared", rets[0], 1);

    // Randomized traffic with random backpressure
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode_in   = 2'($urandom_range(0, 3));
      clr_in    = ($urandom_range(0, 5) == 0);
      a_in      = 8'($urandom);
      b_in      = 8'($urandom);
      cycle();
    end
    drain();
    check("final_idle", out_valid_s | out_valid_w, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
